// File: rtl/nn_mul_pipe_pkg.sv
// nn_mul_pkg: shared types and helpers for the nn_mul_pipe multiplier.
//   nn_mul_mode_t    : per-transaction operand interpretation.
//   NN_MUL_MAX_STAGE : deepest legal pipeline.
//   NN_MUL_EXT_W     : width of the mode-extended product handed to nn_mul_fit;
//                      din0_WIDTH+din1_WIDTH must stay below this.
//   nn_mul_fit()     : overflow bit for narrowing a product to 'width' bits.
package nn_mul_pkg;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } nn_mul_mode_t;

  localparam int NN_MUL_MAX_STAGE = 8;
  localparam int NN_MUL_EXT_W     = 128;

  // 'product' must already be extended to NN_MUL_EXT_W bits by 'mode'.
  // Unsigned: any set bit at or above 'width' overflows.
  // Signed: every bit from width-1 upward must equal the sign bit.
  function automatic logic nn_mul_fit(input logic [NN_MUL_EXT_W-1:0] product,
                                      input nn_mul_mode_t mode,
                                      input int width);
    logic ovf;
    ovf = 1'b0;
    for (int i = 0; i < NN_MUL_EXT_W; i++) begin
      if (mode == MUL_SIGNED) begin
        if (i >= width - 1 && product[i] != product[NN_MUL_EXT_W-1]) ovf = 1'b1;
      end else begin
        if (i >= width && product[i]) ovf = 1'b1;
      end
    end
    return ovf;
  endfunction

endpackage

// File: rtl/nn_mul_pipe_if.sv
// nn_mul_pipe_if: operand/result handshake bundle for nn_mul_pipe.
//   in_valid/in_ready   : operand transfer (source -> multiplier)
//   in_signed, din0/din1: operand mode and values
//   out_valid/out_ready : result transfer (multiplier -> consumer)
//   dout, ovf           : product and its overflow flag
// master = source/consumer side, slave = multiplier side.
interface nn_mul_pipe_if #(
  parameter int din0_WIDTH = 25,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 31
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_signed;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  ovf;

  modport master (
    output in_valid, in_signed, din0, din1, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, in_signed, din0, din1, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/nn_mul_pipe_stage.sv
// nn_mul_pipe_stage: one retiming register (valid, mode, data) advancing on ce.
//   ap_clk, ap_rst_n          : clock, async active-low reset
//   ce                        : pipeline advance enable
//   src_vld/src_mode/src_data : previous stage
//   vld/mode/data             : this stage
module nn_mul_pipe_stage
  import nn_mul_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ce,
  input  logic          src_vld,
  input  nn_mul_mode_t  src_mode,
  input  logic [DW-1:0] src_data,
  output logic          vld,
  output nn_mul_mode_t  mode,
  output logic [DW-1:0] data
);

  // Data is cleared too so the output port reads zero straight out of reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld  <= 1'b0;
      mode <= MUL_UNSIGNED;
      data <= '0;
    end else if (ce) begin
      vld  <= src_vld;
      mode <= src_mode;
      data <= src_data;
    end
  end

endmodule

// File: rtl/nn_mul_pipe.sv
// nn_mul_pipe: pipelined din0 x din1 multiplier with valid/ready flow control
// and per-transaction signed/unsigned mode.
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : in_valid/in_ready/in_signed/din0/din1,
//                      out_valid/out_ready/dout/ovf
// Parameters: din0_WIDTH, din1_WIDTH, dout_WIDTH, NUM_STAGE (1..8).
// Build option: NN_MUL_SAT_EN -- saturate dout on overflow instead of wrapping.
// The multiply and narrowing happen in stage 0; stages 1..NUM_STAGE-1 only
// retime {ovf, dout}. The whole pipe advances together on ce.
module nn_mul_pipe
  import nn_mul_pkg::*;
#(
  parameter int din0_WIDTH = 25,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 31,
  parameter int NUM_STAGE  = 3
) (
  input logic          ap_clk,
  input logic          ap_rst_n,
  nn_mul_pipe_if.slave bus
);

  localparam int P  = din0_WIDTH + din1_WIDTH;
  localparam int DW = dout_WIDTH + 1;  // {ovf, dout}

`ifdef NN_MUL_SAT_EN
  function automatic logic [dout_WIDTH-1:0] sat_narrow(
      input logic [NN_MUL_EXT_W-1:0] p, input nn_mul_mode_t m, input logic ovf);
    logic [dout_WIDTH-1:0] r;
    r = p[dout_WIDTH-1:0];
    if (ovf) begin
      if (m == MUL_SIGNED)
        r = p[NN_MUL_EXT_W-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                              : {1'b0, {(dout_WIDTH-1){1'b1}}};
      else
        r = '1;
    end
    return r;
  endfunction
`endif

  logic ce;
  assign ce           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = ce;

  nn_mul_mode_t                mode_in;
  logic signed [P-1:0]         a_ext, b_ext, prod;
  logic [NN_MUL_EXT_W-1:0]     prod_ext;
  logic                        ovf_c;
  logic [dout_WIDTH-1:0]       res_c;

  assign mode_in = bus.in_signed ? MUL_SIGNED : MUL_UNSIGNED;

  // The low P bits of a P x P multiply are the exact product for either
  // interpretation once the operands are extended by the same rule.
  always_comb begin
    a_ext = {{din1_WIDTH{1'b0}}, bus.din0};
    b_ext = {{din0_WIDTH{1'b0}}, bus.din1};
    if (mode_in == MUL_SIGNED) begin
      a_ext = {{din1_WIDTH{bus.din0[din0_WIDTH-1]}}, bus.din0};
      b_ext = {{din0_WIDTH{bus.din1[din1_WIDTH-1]}}, bus.din1};
    end
    prod     = a_ext * b_ext;
    prod_ext = (mode_in == MUL_SIGNED) ? {{(NN_MUL_EXT_W-P){prod[P-1]}}, prod}
                                       : {{(NN_MUL_EXT_W-P){1'b0}}, prod};
    ovf_c    = nn_mul_fit(prod_ext, mode_in, dout_WIDTH);
`ifdef NN_MUL_SAT_EN
    res_c    = sat_narrow(prod_ext, mode_in, ovf_c);
`else
    res_c    = prod_ext[dout_WIDTH-1:0];
`endif
  end

  logic         vld_pn  [NUM_STAGE];
  nn_mul_mode_t mode_pn [NUM_STAGE];
  logic [DW-1:0] data_pn [NUM_STAGE];

  logic          vld_p0;
  nn_mul_mode_t  mode_p0;
  logic [DW-1:0] data_p0;

  // ---- stage 0: multiply result registered ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p0  <= 1'b0;
      mode_p0 <= MUL_UNSIGNED;
      data_p0 <= '0;
    end else if (ce) begin
      vld_p0  <= bus.in_valid;
      mode_p0 <= mode_in;
      data_p0 <= {ovf_c, res_c};
    end
  end

  assign vld_pn[0]  = vld_p0;
  assign mode_pn[0] = mode_p0;
  assign data_pn[0] = data_p0;

  // ---- stages 1..NUM_STAGE-1: retiming ----
  for (genvar i = 1; i < NUM_STAGE; i++) begin : g_stage
    nn_mul_pipe_stage #(.DW(DW)) u_stage (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .ce       (ce),
      .src_vld  (vld_pn[i-1]),
      .src_mode (mode_pn[i-1]),
      .src_data (data_pn[i-1]),
      .vld      (vld_pn[i]),
      .mode     (mode_pn[i]),
      .data     (data_pn[i])
    );
  end

  // ---- output: last stage drives the bus ----
  assign bus.out_valid        = vld_pn[NUM_STAGE-1];
  assign {bus.ovf, bus.dout}  = data_pn[NUM_STAGE-1];

  // The mode has already been folded into {ovf, dout}; only kept per stage.
  nn_mul_mode_t unused_mode_last;
  assign unused_mode_last = mode_pn[NUM_STAGE-1];

endmodule

// File: tb/tb_nn_mul_pipe.sv
// Scoreboard bench for nn_mul_pipe. dut_a: defaults (31-bit out, 3 stages);
// dut_b: 8-bit out, 1 stage. Expected results come from plain integer
// arithmetic on the operands; a negedge monitor pops and compares.
module tb_nn_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  nn_mul_pipe_if #(.din0_WIDTH(25), .din1_WIDTH(6), .dout_WIDTH(31)) bus_a ();
  nn_mul_pipe_if #(.din0_WIDTH(25), .din1_WIDTH(6), .dout_WIDTH(8))  bus_b ();

  nn_mul_pipe #(.din0_WIDTH(25), .din1_WIDTH(6), .dout_WIDTH(31), .NUM_STAGE(3)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_a));
  nn_mul_pipe #(.din0_WIDTH(25), .din1_WIDTH(6), .dout_WIDTH(8), .NUM_STAGE(1)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic [63:0] dout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Exact product in plain integers, then fit/wrap/saturate to w bits.
  function automatic exp_t model(input bit s, input logic [24:0] a, input logic [5:0] b, input int w);
    exp_t e;
    longint av, bv, p, lo, hi, mask, r;
    av   = s ? longint'($signed(a)) : longint'(a);
    bv   = s ? longint'($signed(b)) : longint'(b);
    p    = av * bv;
    mask = (longint'(1) <<< w) - 1;
    if (s) begin
      lo = -(longint'(1) <<< (w - 1));
      hi = -lo - 1;
    end else begin
      lo = 0;
      hi = mask;
    end
    e.ovf = (p < lo) || (p > hi);
    r = p;
`ifdef NN_MUL_SAT_EN
    if (p > hi) r = hi;
    else if (p < lo) r = lo;
`endif
    e.dout = 64'(r & mask);
    e.acc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  // One cycle of stimulus on DUT d; pushes the expectation if accepted.
  task automatic issue(input int d, input bit v, input bit s, input logic [24:0] a,
                       input logic [5:0] b, input bit ordy, input bit lat, output bit acc);
    exp_t e;
    @(posedge clk);
    #2;
    if (d == 0) begin
      bus_a.in_valid = v; bus_a.in_signed = s; bus_a.din0 = a; bus_a.din1 = b;
      bus_a.out_ready = ordy;
    end else begin
      bus_b.in_valid = v; bus_b.in_signed = s; bus_b.din0 = a; bus_b.din1 = b;
      bus_b.out_ready = ordy;
    end
    #1;
    acc = v && ((d == 0) ? bus_a.in_ready : bus_b.in_ready);
    if (acc) begin
      e = model(s, a, b, (d == 0) ? 31 : 8);
      e.acc = cyc;
      e.lat = lat;
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic go(input int d, input bit v, input bit s, input logic [24:0] a,
                    input logic [5:0] b, input bit ordy, input bit lat);
    bit acc;
    issue(d, v, s, a, b, ordy, lat, acc);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) go(d, 1'b0, 1'b0, 25'd0, 6'd0, 1'b1, 1'b0);
  endtask

  task automatic drain(input int d);
    int left;
    left = (d == 0) ? qa.size() : qb.size();
    for (int i = 0; i < 200 && left != 0; i++) begin
      idle(d, 1);
      left = (d == 0) ? qa.size() : qb.size();
    end
    check((d == 0) ? "drain_a" : "drain_b", 64'(left), 64'd0);
  endtask

  // Random stream: the source holds each pair until it is accepted.
  task automatic stream(input int d, input int n, input bit rand_ready);
    bit acc, s, ordy;
    logic [24:0] a;
    logic [5:0] b;
    for (int k = 0; k < n; k++) begin
      s = 1'($urandom_range(0, 1));
      a = 25'($urandom);
      b = 6'($urandom);
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        ordy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        issue(d, 1'b1, s, a, b, ordy, !rand_ready, acc);
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  // ---------------- monitor ----------------
  bit          held [2];
  logic [63:0] hd   [2];
  logic        ho   [2];

  task automatic mon(input int d, input bit ov, input bit ordy, input logic [63:0] dv, input logic ovf);
    exp_t e;
    int n;
    if (held[d]) begin
      check("stall_valid", 64'(ov), 64'd1);
      check("stall_dout", dv, hd[d]);
      check("stall_ovf", 64'(ovf), 64'(ho[d]));
    end
    held[d] = 1'b0;
    if (ov && !ordy) begin
      held[d] = 1'b1; hd[d] = dv; ho[d] = ovf;
    end
    if (ov && ordy) begin
      n = (d == 0) ? qa.size() : qb.size();
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output dut=%0d actual=%0h required=none", d, dv);
      end else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        check((d == 0) ? "dout_a" : "dout_b", dv, e.dout);
        check((d == 0) ? "ovf_a" : "ovf_b", 64'(ovf), 64'(e.ovf));
        if (e.lat)
          check((d == 0) ? "latency_a" : "latency_b", 64'(cyc - e.acc), (d == 0) ? 64'd3 : 64'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      mon(0, bus_a.out_valid, bus_a.out_ready, 64'(bus_a.dout), bus_a.ovf);
      mon(1, bus_b.out_valid, bus_b.out_ready, 64'(bus_b.dout), bus_b.ovf);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_signed = 1'b0; bus_a.din0 = '0; bus_a.din1 = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_signed = 1'b0; bus_b.din0 = '0; bus_b.din1 = '0;
    bus_b.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid_a", 64'(bus_a.out_valid), 64'd0);
    check("rst_dout_a", 64'(bus_a.dout), 64'd0);
    check("rst_ovf_a", 64'(bus_a.ovf), 64'd0);
    check("rst_out_valid_b", 64'(bus_b.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset_a", 64'(bus_a.in_ready), 64'd1);
    check("in_ready_after_reset_b", 64'(bus_b.in_ready), 64'd1);

    // Directed, default widths: 1000*63, signed -5*-32, same operands unsigned.
    go(0, 1'b1, 1'b0, 25'd1000, 6'd63, 1'b1, 1'b1);
    idle(0, 1);
    go(0, 1'b1, 1'b1, 25'h1FFFFFB, 6'h20, 1'b1, 1'b1);
    go(0, 1'b1, 1'b0, 25'h1FFFFFB, 6'h20, 1'b1, 1'b1);
    drain(0);

    // Directed, 8-bit result: 200*3 overflow, signed -100*2, -100*-2, 10*5.
    go(1, 1'b1, 1'b0, 25'd200, 6'd3, 1'b1, 1'b1);
    go(1, 1'b1, 1'b1, 25'h1FFFF9C, 6'd2, 1'b1, 1'b1);
    go(1, 1'b1, 1'b1, 25'h1FFFF9C, 6'h3E, 1'b1, 1'b1);
    go(1, 1'b1, 1'b0, 25'd10, 6'd5, 1'b1, 1'b1);
    drain(1);

    // Single stage, continuous valid and ready: one result per cycle.
    stream(1, 12, 1'b0);
    drain(1);

    // Random streams with out_ready toggling.
    stream(0, 20, 1'b1);
    drain(0);
    stream(1, 20, 1'b1);
    drain(1);

    // Fill dut_a with three results while stalled, then reset mid-stream.
    go(0, 1'b1, 1'b0, 25'd7, 6'd9, 1'b0, 1'b0);
    go(0, 1'b1, 1'b1, 25'h1FFFFF0, 6'd5, 1'b0, 1'b0);
    go(0, 1'b1, 1'b0, 25'd123, 6'd45, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    bus_a.in_valid = 1'b0;
    check("full_before_reset", 64'(bus_a.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("mid_rst_dout", 64'(bus_a.dout), 64'd0);
    check("mid_rst_ovf", 64'(bus_a.ovf), 64'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    go(0, 1'b1, 1'b1, 25'd300, 6'h3F, 1'b1, 1'b1);
    idle(0, 8);
    check("post_reset_single_output", 64'(qa.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_mul_pipe.md
# nn_mul_pipe

Parametrised, pipelined integer multiplier with valid/ready flow control and per-transaction signed/unsigned mode. It is the next-generation replacement for the fixed-width combinational `NN_mul_*` cores in the AlexNet datapath, for MAC and scaling paths that need registered timing closure and backpressure. It delivers one product per cycle at full throughput and stalls cleanly when the consumer holds off.

## Interface
- `din0_WIDTH`, 25: operand A width.
- `din1_WIDTH`, 6: operand B width.
- `dout_WIDTH`, 31: result width. May be smaller than `din0_WIDTH+din1_WIDTH`.
- `NUM_STAGE`, 3: pipeline depth in register stages. Legal range 1..8.
- `ap_clk`  in  1  clock; all state updates on the rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair is valid.
- `in_ready`  out  1  block accepts an operand pair this cycle.
- `in_signed`  in  1  1: both operands are two's complement; 0: both are unsigned.
- `din0`  in  `din0_WIDTH`  operand A.
- `din1`  in  `din1_WIDTH`  operand B.
- `out_valid`  out  1  `dout` holds a result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `dout`  out  `dout_WIDTH`  product.
- `ovf`  out  1  the full product did not fit `dout_WIDTH` under the selected mode.

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Advance enable: `ce = !out_valid || out_ready`. `in_ready = ce`. The whole pipeline shifts only when `ce` is 1. There are no bubbles to collapse.
- Each stage holds a valid bit, a mode bit and data. On `ce`:
  - Stage 0 loads `in_valid` and the operands.
  - Every later stage loads the stage before it.
- Product formation:
  - Operands are extended to `P = din0_WIDTH+din1_WIDTH` bits: sign-extended if `in_signed` is 1, zero-extended if it is 0.
  - The multiplication produces an exact P-bit product.
  - The multiply sits in stage 0. Later stages are retiming registers. `NUM_STAGE=1` means a single registered output.
- Narrowing to `dout_WIDTH` without `NN_MUL_SAT_EN`: `dout` takes the low `dout_WIDTH` bits of the P-bit product (wrap).
- If `dout_WIDTH >= P`, the product is extended to `dout_WIDTH` by the transaction's mode and `ovf` is always 0.
- `ovf` is computed in every build; it qualifies `dout` only while `out_valid` is 1.
- The mode is carried per transaction, so back-to-back signed and unsigned operations are legal.

## Timing
- Reset (async assert, sync release): all stage valid bits = 0, `out_valid` = 0, `dout` = 0, `ovf` = 0. `in_ready` is 1 from the first cycle after reset.
- Latency: an input accepted in cycle t appears with `out_valid`=1 in cycle t+NUM_STAGE, provided no stall occurs.
- Throughput: 1 per cycle while `out_ready` is held at 1.
- Stall: `out_valid && !out_ready` freezes every stage. `dout`, `ovf` and `out_valid` hold steady. `in_ready` drops in the same cycle (combinational from `out_ready`).
- Simultaneous output and input transfer in one cycle is legal; no data is lost.
- Reset asserted mid-stream discards all in-flight results. No partial output is produced.
- `in_valid` while `in_ready`=0 is ignored. The source must hold its data.

## Configuration
- `NN_MUL_SAT_EN` defined: on overflow, `dout` saturates.
  - Unsigned: to all-ones.
  - Signed: to max positive or min negative, following the product's sign.
- `NN_MUL_SAT_EN` undefined: `dout` wraps.
- In both builds `ovf` behaves identically.

## Structure
- Package `nn_mul_pkg` holds:
  - `nn_mul_mode_t` enum: `MUL_UNSIGNED`, `MUL_SIGNED`.
  - Function `nn_mul_fit(product, mode, width)` returning the overflow bit.
  - Constant `NN_MUL_MAX_STAGE` = 8.
- One sub-module, `nn_mul_pipe_stage`: a valid, mode and data register with `ce`, instantiated via generate `NUM_STAGE-1` times after the multiply stage.

## Test plan
- Defaults, unsigned, 25'd1000 × 6'd63 → `dout`=63000, `ovf`=0, exactly 3 cycles after acceptance.
- Defaults, signed, din0=−5 (25'h1FFFFFB) × din1=−32 (6'h20) → `dout`=160, `ovf`=0. The same operands unsigned → 33554427×32 = 1073741664, `ovf`=0.
- `dout_WIDTH`=8, unsigned 200×3:
  - Without the macro → `dout`=88, `ovf`=1.
  - With `NN_MUL_SAT_EN` → `dout`=255, `ovf`=1.
  - Signed −100×2 with `NN_MUL_SAT_EN` → −128.
- Stream of 20 operand pairs with `out_ready` toggling pseudo-randomly → all results in order, none dropped or duplicated, and `dout` stable during every stall.
- Assert `ap_rst_n` low with 3 results in flight → `out_valid`=0 and `dout`=0 immediately. After release, the first new input yields exactly one output at t+3.
- `NUM_STAGE`=1, continuous valid and ready → 1-cycle latency and one result per cycle.
